// File: rtl/issue_scheduler.sv
// issue_scheduler: single-entry issue stage with RAW/WAW scoreboard and drain/report/halt exception sequencing; ports: dec/decValid/decReady in, uop/uopValid/uopReady out, wbValid/wbRd writeback, excValid/excReady report, flush, halted
package Uop;
    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        immValid;
        logic [2:0]  fu;
        logic [3:0]  op;
        logic [1:0]  memOp;
        logic        exValid;
    } dec_t;
endpackage

module issue_scheduler #(
    parameter int NREGS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       decValid,
    output logic       decReady,
    input  Uop::dec_t  dec,
    output logic       uopValid,
    input  logic       uopReady,
    output Uop::dec_t  uop,
    input  logic       wbValid,
    input  logic [4:0] wbRd,
    output logic       excValid,
    input  logic       excReady,
    input  logic       flush,
    output logic       halted
);
    typedef enum logic [1:0] {RUN, DRAIN, EXC, HALT} state_t;
    state_t state;
    logic full;
    logic [NREGS-1:0] busy, wb_mask, set_mask, busy_eff, busy_next, src_mask;
    logic blocked, issue_fire, accept;
    always_comb begin
        wb_mask = wbValid ? NREGS'(1) << wbRd : '0;
        busy_eff = busy & ~wb_mask;
        src_mask = ((NREGS'(1) << uop.rs1) | (NREGS'(1) << uop.rs2) | (NREGS'(1) << uop.rd)) & ~NREGS'(1);
        blocked = |(busy_eff & src_mask);
        uopValid = state == RUN && full && !uop.exValid && !blocked;
        issue_fire = uopValid && uopReady;
        decReady = state == RUN && !flush && (!full || issue_fire);
        accept = decValid && decReady;
        set_mask = issue_fire ? NREGS'(1) << uop.rd : '0;
        // set is OR-ed after the clear so an issue and a writeback to the same register leave it busy
        busy_next = (busy_eff | set_mask) & ~NREGS'(1);
        excValid = state == EXC;
        halted = state == HALT;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            full <= 1'b0;
            busy <= '0;
            uop <= '0;
        end else begin
            busy <= busy_next;
            if (flush) begin
                state <= RUN;
                full <= 1'b0;
            end else begin
                if (accept) begin
                    uop <= dec;
                    full <= 1'b1;
                end else if (issue_fire || (state == EXC && excReady)) begin
                    full <= 1'b0;
                end
                state <= (state == RUN && full && uop.exValid) ? (|busy ? DRAIN : EXC)
                       : (state == DRAIN && !(|busy_next)) ? EXC
                       : (state == EXC && excReady) ? HALT
                       : state;
            end
        end
    end
endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Single-entry issue stage between the instruction decoder and the functional units. It accepts decoded micro-ops over a valid/ready handshake and holds each one in an issue register. A 32-entry register scoreboard stalls any uop with RAW or WAW hazards. Decode exceptions are sequenced through drain, report and halt states until the front end issues a flush.

## Interface
- NREGS, default 32: number of architectural registers (scoreboard depth); register 0 is hardwired zero and never busy.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- decValid  in  1  decoded uop on `dec` is valid.
- decReady  out  1  scheduler accepts `dec` this cycle.
- dec  in  Uop::dec_t  decoded uop: rd, rs1, rs2, imm, immValid, fu, op, memOp, exValid.
- uopValid  out  1  issue register holds an issuable uop.
- uopReady  in  1  functional unit accepts the uop.
- uop  out  Uop::dec_t  contents of the issue register.
- wbValid  in  1  writeback completes this cycle.
- wbRd  in  5  register being written back.
- excValid  out  1  decode exception pending report.
- excReady  in  1  exception handler accepts the report.
- flush  in  1  synchronous flush from the front end.
- halted  out  1  scheduler is in HALT.

## Operation
- **State machine.** There are four states: RUN, DRAIN, EXC and HALT. Reset enters RUN.
- **Issue register.** It holds one uop plus a `full` bit.
  - decReady = RUN && (!full || issueFire).
  - A uop is accepted when decValid && decReady.
- **Hazard check.** Let busyEff = busy & ~(wbValid ? onehot(wbRd) : 0), so a writeback in the same cycle unblocks issue.
  - The held uop is blocked if busyEff[rs1], busyEff[rs2] or busyEff[rd] is set.
  - Index 0 is ignored.
- **Issue handshake.**
  - uopValid = RUN && full && !exValid(held) && !blocked.
  - issueFire = uopValid && uopReady.
- **Scoreboard update.**
  - On issueFire with rd != 0, set busy[rd].
  - On wbValid, clear busy[wbRd].
  - If both hit the same register in one cycle, set wins.
  - Stores (rd = 0) never set a bit.
- **Exception path.** When the held uop has exValid and the state is RUN, it is never issued. Next state:
  - DRAIN if busy != 0.
  - EXC otherwise.
- **DRAIN.**
  - decReady = 0 and uopValid = 0; writebacks continue clearing busy bits.
  - Move to EXC in the cycle after busy becomes 0.
- **EXC.**
  - excValid = 1, held stable until excReady.
  - On excValid && excReady: clear full and go to HALT.
- **HALT.** halted = 1 and decReady = 0.
- **flush.** Valid in any state; it has priority over every other transition.
  - Clear full and go to RUN.
  - The scoreboard is not cleared, because in-flight writebacks still arrive.
- **Stability.** uop must stay stable while uopValid && !uopReady. Only the issue register feeds it, and the register changes only on issueFire or accept.

## Timing
- **Reset values.**
  - State RUN, full = 0, busy = 0.
  - decReady = 1, uopValid = 0, uop = 0, excValid = 0, halted = 0.
- **Latency.**
  - A uop accepted in cycle N is presented on uopValid in cycle N+1 at the earliest.
  - Back-to-back throughput is 1 uop/cycle when there are no hazards and uopReady is held high.
- **Dependent pair.** A uop following a producer with the same rd/rs issues in the cycle its producer's wbValid is asserted, or later.
- **Exception timing.** An exception held in cycle N with busy = 0 gives excValid in cycle N+1. Each drain cycle adds one.
- **flush in the same cycle as decValid.** The decoded uop is dropped (decReady forced to 0 that cycle).
- **rst mid-operation.** rst asserted in any state returns every output to its reset value immediately, without waiting for a clock edge.
- **uopReady without uopValid.** uopReady may be asserted while uopValid = 0 and has no effect.

## Test plan
- **Independent stream.** Send add x1,x2,x3, then add x4,x5,x6, then add x7,x8,x9, with uopReady = 1 and no writebacks.
  - Required: three issues in consecutive cycles.
  - Required: busy = 0x92 afterwards.
- **RAW stall.** Issue add x5,x1,x2, then add x6,x5,x3. Hold off wbRd = 5 for 4 cycles.
  - Required: the second uop is held with uopValid = 0.
  - Required: it issues in the same cycle that wbValid = 1, wbRd = 5.
- **Store, then set/clear collision.**
  - Store with rd = 0: busy is unchanged.
  - Issue rd = 3 in the same cycle as a writeback to 3: busy[3] = 1 afterwards.
- **Exception with drain.** Load x9 in flight, then a uop with exValid = 1.
  - Required: state DRAIN, with decReady = 0 and uopValid = 0.
  - Writeback to x9: excValid = 1 on the next cycle.
  - excReady = 1: halted = 1.
  - flush: state RUN, decReady = 1.
- **Backpressure.** Hold uopReady = 0 for 5 cycles with decValid = 1.
  - Required: uop stays stable and decReady = 0.
  - Required: exactly one uop is accepted per issue once released.
- **Async reset mid-stall.** Assert rst during DRAIN, between clock edges.
  - Required: busy = 0, state RUN and all outputs at reset values before the next edge.
